tt_pin_reg_responder: RTL and testbench

Register-access responder behind the standard tile pin interface.
An external initiator (host or testbench) sends command and data bytes on ui_in using a four-phase req/ack handshake on the uio pins.
The block services reads and writes to a small 8-bit register file and presents read data on uo_out.
It is the responder end of the pin-level host protocol and sits directly under the top-level wrapper.

---
 rtl/tt_pin_reg_responder_if.sv | 25 ++
 rtl/tt_pin_reg_responder.sv | 162 ++++++++++++++++
 tb/tb_tt_pin_reg_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tt_pin_reg_responder_if.sv
// Tile pin bundle between the host-side initiator and the register responder.
//   ena     : design enable from the tile wrapper
//   ui_in   : command/data byte from the initiator
//   uo_out  : read-data byte back to the initiator
//   uio_in  : bit0 = req from the initiator
//   uio_out : bit1 = ack, bit2 = err
//   uio_oe  : output enables for the uio pins
interface tt_pin_reg_responder_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_pin_reg_responder.sv
// Register-access responder on the tile pins. The initiator sends a command
// byte (bit7 = write, bits3:0 = address) and, for writes, a data byte, each
// with a four-phase req/ack handshake. Reads return data on uo_out.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   pins  : tile pin bundle (slave side)
//
// state     | meaning
// IDLE      | waiting for a command byte
// CMD_ACK   | command acknowledged, waiting for req to fall
// WAIT_DATA | write command taken, waiting for the data byte
// DATA_ACK  | data byte acknowledged, waiting for req to fall
module tt_pin_reg_responder #(
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input logic                   clk,
  input logic                   rst_n,
  tt_pin_reg_responder_if.slave pins
);

  typedef enum logic [1:0] {IDLE, CMD_ACK, WAIT_DATA, DATA_ACK} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   req_s;
  logic                   rise;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   pend_q, pend_d;
  logic [3:0]             addr_q, addr_d;
  logic [3:0]             cmd_addr;
  logic [7:0]             uo_q, uo_d;
  logic [7:0]             rdata;
  logic                   wr_en;
  logic [7:0]             regs [1:NUM_REGS-1];
  logic [9:0]             unused_pins;

  function automatic logic in_range(input logic [3:0] a);
    return (a != 4'd0) && (int'(a) < NUM_REGS);
  endfunction

  assign unused_pins = {pins.uio_in[7:1], pins.ui_in[6:4]};

  assign req_s    = sync_q[SYNC_STAGES-1];
  assign rise     = req_s & ~prev_q;
  assign cmd_addr = pins.ui_in[3:0];

  // The synchronizer comes out of reset full of zeros, which is not a real
  // observation of req. prev is held at 1 until the chain holds genuine
  // samples, so a req held high through reset never looks like a new edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pins.uio_in[0]};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= fill_q[SYNC_STAGES-1] ? req_s : 1'b1;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (cmd_addr == 4'd0) rdata = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (cmd_addr == 4'(i)) rdata = regs[i];
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = err_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    uo_d    = uo_q;
    wr_en   = 1'b0;
    if (!pins.ena) begin
      state_d = IDLE;
      ack_d   = 1'b0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            ack_d   = 1'b1;
            err_d   = 1'b0;
            addr_d  = cmd_addr;
            state_d = CMD_ACK;
            if (pins.ui_in[7]) begin
              pend_d = 1'b1;
            end else begin
              pend_d = 1'b0;
              uo_d   = rdata;
              if (cmd_addr != 4'd0 && !in_range(cmd_addr)) err_d = 1'b1;
            end
          end
        end
        CMD_ACK: begin
          if (!req_s) begin
            ack_d   = 1'b0;
            state_d = pend_q ? WAIT_DATA : IDLE;
          end
        end
        WAIT_DATA: begin
          if (rise) begin
            ack_d   = 1'b1;
            pend_d  = 1'b0;
            state_d = DATA_ACK;
            if (in_range(addr_q)) wr_en = 1'b1;
            else                  err_d = 1'b1;
          end
        end
        DATA_ACK: begin
          if (!req_s) begin
            ack_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      addr_q  <= 4'd0;
      uo_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      uo_q    <= uo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else if (wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (addr_q == 4'(i)) regs[i] <= pins.ui_in;
      end
    end
  end

  assign pins.uo_out  = uo_q;
  assign pins.uio_out = {5'b0, err_q, ack_q, 1'b0};
  assign pins.uio_oe  = 8'b0000_0110;

endmodule

// File: tb/tb_tt_pin_reg_responder.sv
module tb_tt_pin_reg_responder;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   rc, fc;

  tt_pin_reg_responder_if pins ();

  tt_pin_reg_responder #(
    .NUM_REGS   (8),
    .SYNC_STAGES(2),
    .ID_VALUE   (8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pins (pins.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full four-phase handshake for one byte; returns cycles from req rise to
  // ack rise and from req fall to ack fall (0 means the bound expired).
  task automatic send_byte(input logic [7:0] b, output int r, output int f);
    pins.ui_in  = b;
    pins.uio_in = 8'h01;
    r = 0;
    for (int i = 1; i <= 20 && r == 0; i++) begin
      @(posedge clk);
      #1;
      if (pins.uio_out[1]) r = i;
    end
    pins.uio_in = 8'h00;
    f = 0;
    for (int i = 1; i <= 20 && f == 0; i++) begin
      @(posedge clk);
      #1;
      if (!pins.uio_out[1]) f = i;
    end
  endtask

  task automatic xfer(input string tag, input logic [7:0] b);
    send_byte(b, rc, fc);
    check_val({tag, "_ack_rise"}, rc, 3);
    check_val({tag, "_ack_fall"}, fc, 3);
  endtask

  initial begin
    rst_n       = 1'b0;
    pins.ena    = 1'b1;
    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h00;
    wait_cycles(4);
    rst_n = 1'b1;
    wait_cycles(2);

    check_val("rst_uo_out", pins.uo_out, 8'h00);
    check_val("rst_uio_out", pins.uio_out, 8'h00);
    check_val("rst_uio_oe", pins.uio_oe, 8'h06);

    xfer("rd_id", 8'h00);
    check_val("rd_id_data", pins.uo_out, 8'hA5);
    check_val("rd_id_err", pins.uio_out[2], 1'b0);

    xfer("wr5_cmd", 8'h85);
    check_val("wr5_uo_hold", pins.uo_out, 8'hA5);
    xfer("wr5_data", 8'h3C);
    check_val("wr5_uo_hold2", pins.uo_out, 8'hA5);
    xfer("rd5", 8'h05);
    check_val("rd5_data", pins.uo_out, 8'h3C);
    check_val("rd5_err", pins.uio_out[2], 1'b0);

    xfer("wr0_cmd", 8'h80);
    xfer("wr0_data", 8'h77);
    check_val("wr0_err", pins.uio_out, 8'h04);
    xfer("rd0_after", 8'h00);
    check_val("rd0_after_data", pins.uo_out, 8'hA5);
    check_val("rd0_after_err", pins.uio_out[2], 1'b0);

    xfer("wr2_cmd", 8'h82);
    xfer("wr2_data", 8'h5A);
    xfer("rd_oob", 8'h0A);
    check_val("rd_oob_data", pins.uo_out, 8'h00);
    check_val("rd_oob_err", pins.uio_out[2], 1'b1);
    xfer("wr_oob_cmd", 8'h8A);
    xfer("wr_oob_data", 8'hFF);
    check_val("wr_oob_err", pins.uio_out[2], 1'b1);
    xfer("rd2", 8'h02);
    check_val("rd2_data", pins.uo_out, 8'h5A);
    check_val("rd2_err", pins.uio_out[2], 1'b0);

    xfer("wr7_cmd", 8'h87);
    xfer("wr7_data", 8'h11);
    check_val("wr7_err", pins.uio_out[2], 1'b0);
    xfer("rd7", 8'h07);
    check_val("rd7_data", pins.uo_out, 8'h11);
    check_val("rd7_err", pins.uio_out[2], 1'b0);
    xfer("rd8", 8'h08);
    check_val("rd8_data", pins.uo_out, 8'h00);
    check_val("rd8_err", pins.uio_out[2], 1'b1);

    // Drop ena while a write waits for its data byte.
    xfer("rd2b", 8'h02);
    check_val("rd2b_data", pins.uo_out, 8'h5A);
    xfer("wr3_cmd", 8'h83);
    pins.ena = 1'b0;
    wait_cycles(3);
    check_val("ena_off_ack", pins.uio_out[1], 1'b0);
    pins.ena = 1'b1;
    wait_cycles(2);
    xfer("ena_rd3", 8'h03);
    check_val("ena_rd3_data", pins.uo_out, 8'h00);
    check_val("ena_rd3_err", pins.uio_out[2], 1'b0);
    xfer("ena_rd3b", 8'h03);
    check_val("ena_rd3b_data", pins.uo_out, 8'h00);

    // req held high across reset release must not start a command.
    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h01;
    rst_n = 1'b0;
    wait_cycles(4);
    rst_n = 1'b1;
    wait_cycles(10);
    check_val("rst_req_hi_uio", pins.uio_out, 8'h00);
    check_val("rst_req_hi_uo", pins.uo_out, 8'h00);
    pins.uio_in = 8'h00;
    wait_cycles(5);
    check_val("rst_req_lo_uio", pins.uio_out, 8'h00);
    xfer("rst_rd_id", 8'h00);
    check_val("rst_rd_id_data", pins.uo_out, 8'hA5);
    xfer("rst_rd5", 8'h05);
    check_val("rst_rd5_data", pins.uo_out, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
